// File: rtl/snd_dma_addr_pkg.sv
// Shared definitions for the sound DMA address unit: register select codes,
// address width and byte pack/unpack helpers for 21-bit word addresses.
package snd_dma_addr_pkg;

  localparam int AW      = 21;
  localparam int HI_BITS = AW - 15 - 1 + 1;  // bits 21:16 of the byte address

  typedef enum logic [3:0] {
    SEL_START_HI  = 4'd0,
    SEL_START_MID = 4'd1,
    SEL_START_LO  = 4'd2,
    SEL_CNT_HI    = 4'd3,
    SEL_CNT_MID   = 4'd4,
    SEL_CNT_LO    = 4'd5,
    SEL_END_HI    = 4'd6,
    SEL_END_MID   = 4'd7,
    SEL_END_LO    = 4'd8
  } sel_e;

  typedef enum logic [1:0] {
    BYTE_HI  = 2'd0,
    BYTE_MID = 2'd1,
    BYTE_LO  = 2'd2
  } byte_e;

  // Readback view of one byte of a word address held as byte-address bits [21:1].
  function automatic logic [7:0] addr_byte(input logic [AW:1] a, input byte_e b);
    logic [7:0] r;
    r = '0;
    case (b)
      BYTE_HI:  r = {{(8-HI_BITS){1'b0}}, a[AW:16]};
      BYTE_MID: r = a[15:8];
      BYTE_LO:  r = {a[7:1], 1'b0};
      default:  r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [AW:1] addr_set_byte(input logic [AW:1] a, input byte_e b,
                                                input logic [7:0] d);
    logic [AW:1] r;
    r = a;
    case (b)
      BYTE_HI:  r[AW:16] = d[HI_BITS-1:0];
      BYTE_MID: r[15:8]  = d;
      BYTE_LO:  r[7:1]   = d[7:1];
      default:  r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/snd_dma_addr_reg.sv
// Byte-writable 21-bit word-address register with hi/mid/lo write and readback.
module snd_addr_reg
  import snd_dma_addr_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr_en,
  input  byte_e         i_wr_byte,
  input  logic [7:0]    i_wr_data,
  input  byte_e         i_rd_byte,
  output logic [7:0]    o_rd_data,
  output logic [AW:1]   o_addr
);

  logic [AW:1] r_addr;

  // NOTE: state is updated with non-blocking assignments and cleared by the
  // asynchronous reset, so every reader sees the pre-edge value in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if (i_wr_en) begin
      r_addr <= addr_set_byte(r_addr, i_wr_byte, i_wr_data);
    end
  end

  assign o_rd_data = addr_byte(r_addr, i_rd_byte);
  assign o_addr    = r_addr;

endmodule

// File: rtl/snd_dma_addr.sv
// Sound DMA address unit: start/end shadows, double-buffered active frame,
// 21-bit word address counter and coherent counter readback.
module snd_dma_addr
  import snd_dma_addr_pkg::*;
(
  input  logic          clk32,
  input  logic          porb,
  input  logic          wr_en,
  input  logic [3:0]    wr_sel,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [3:0]    rd_sel,
  output logic [7:0]    rd_data,
  input  logic          sndon,
  input  logic          sndclk_en,
  input  logic          sframe_n,
  output logic [AW:1]   snd,
  output logic [AW:1]   sft
);

  logic          w_start_wr;
  logic          w_end_wr;
  logic [3:0]    w_end_wr_idx;
  logic [3:0]    w_end_rd_idx;
  logic [7:0]    w_start_rd;
  logic [7:0]    w_end_rd;
  logic [AW:1]   w_start;
  logic [AW:1]   w_end;
  logic          w_reload;

  logic [AW:1]   r_snd;
  logic [AW:1]   r_act_end;
  logic [15:1]   r_snap;
  logic          r_sndon_q;
  logic          r_sframe_n_q;

  assign w_start_wr   = wr_en && (wr_sel <= SEL_START_LO);
  assign w_end_wr     = wr_en && (wr_sel >= SEL_END_HI) && (wr_sel <= SEL_END_LO);
  assign w_end_wr_idx = wr_sel - SEL_END_HI;
  assign w_end_rd_idx = rd_sel - SEL_END_HI;

  snd_addr_reg u_start (
    .clk       (clk32),
    .rst_n     (porb),
    .i_wr_en   (w_start_wr),
    .i_wr_byte (byte_e'(wr_sel[1:0])),
    .i_wr_data (wr_data),
    .i_rd_byte (byte_e'(rd_sel[1:0])),
    .o_rd_data (w_start_rd),
    .o_addr    (w_start)
  );

  snd_addr_reg u_end (
    .clk       (clk32),
    .rst_n     (porb),
    .i_wr_en   (w_end_wr),
    .i_wr_byte (byte_e'(w_end_wr_idx[1:0])),
    .i_wr_data (wr_data),
    .i_rd_byte (byte_e'(w_end_rd_idx[1:0])),
    .o_rd_data (w_end_rd),
    .o_addr    (w_end)
  );

  // Reload on sndon rising, or on sframe_n falling while running.
  assign w_reload = (sndon && !r_sndon_q) || (sndon && r_sframe_n_q && !sframe_n);

  always_ff @(posedge clk32 or negedge porb) begin
    if (!porb) begin
      r_snd        <= '0;
      r_act_end    <= '0;
      r_snap       <= '0;
      r_sndon_q    <= 1'b0;
      r_sframe_n_q <= 1'b0;
    end else begin
      r_sndon_q    <= sndon;
      r_sframe_n_q <= sframe_n;
      // Reload sees the pre-write shadow; a same-cycle write lands next reload.
      if (w_reload) begin
        r_snd     <= w_start;
        r_act_end <= w_end;
      end else if (sndon && sndclk_en) begin
        r_snd <= r_snd + 1'b1;
      end
      if (rd_en && (rd_sel == SEL_CNT_HI)) begin
        r_snap <= r_snd[15:1];
      end
    end
  end

  // NOTE: rd_data gets a default before the case so no select leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_data = '0;
    case (rd_sel)
      SEL_START_HI, SEL_START_MID, SEL_START_LO: rd_data = w_start_rd;
      SEL_CNT_HI:                                rd_data = addr_byte(r_snd, BYTE_HI);
      SEL_CNT_MID:                               rd_data = r_snap[15:8];
      SEL_CNT_LO:                                rd_data = {r_snap[7:1], 1'b0};
      SEL_END_HI, SEL_END_MID, SEL_END_LO:       rd_data = w_end_rd;
      default:                                   rd_data = '0;
    endcase
  end

  assign snd = r_snd;
  assign sft = r_act_end;

endmodule

// File: tb/tb_snd_dma_addr.sv
// Scoreboard bench for snd_dma_addr: byte-address reference model, directed
// scenarios followed by randomized traffic.
module tb_snd_dma_addr;

  logic        clk32;
  logic        porb;
  logic        wr_en;
  logic [3:0]  wr_sel;
  logic [7:0]  wr_data;
  logic        rd_en;
  logic [3:0]  rd_sel;
  logic [7:0]  rd_data;
  logic        sndon;
  logic        sndclk_en;
  logic        sframe_n;
  logic [21:1] snd;
  logic [21:1] sft;

  snd_dma_addr dut (
    .clk32     (clk32),
    .porb      (porb),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .sndon     (sndon),
    .sndclk_en (sndclk_en),
    .sframe_n  (sframe_n),
    .snd       (snd),
    .sft       (sft)
  );

  initial clk32 = 1'b0;
  always #5 clk32 = ~clk32;

  typedef struct {
    logic [31:0] snd;
    logic [31:0] sft;
    logic [31:0] rd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: shadows and snapshot as byte addresses, counter as word address.
  int unsigned m_start_b, m_end_b, m_snd, m_sft, m_snap_b;
  bit          m_prev_on, m_prev_sf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int unsigned set_byte(input int unsigned ba, input int pos,
                                           input logic [7:0] d);
    int unsigned r;
    r = ba;
    if (pos == 0)      r = (ba & ~32'h003F_0000) | ((32'(d) & 32'h3F) << 16);
    else if (pos == 1) r = (ba & ~32'h0000_FF00) | (32'(d) << 8);
    else if (pos == 2) r = (ba & ~32'h0000_00FF) | (32'(d) & 32'hFE);
    return r;
  endfunction

  function automatic logic [31:0] model_rd(input int sel);
    int unsigned snd_b;
    snd_b = m_snd << 1;
    case (sel)
      0: return (m_start_b >> 16) & 32'h3F;
      1: return (m_start_b >> 8) & 32'hFF;
      2: return m_start_b & 32'hFF;
      3: return (snd_b >> 16) & 32'h3F;
      4: return (m_snap_b >> 8) & 32'hFF;
      5: return m_snap_b & 32'hFF;
      6: return (m_end_b >> 16) & 32'h3F;
      7: return (m_end_b >> 8) & 32'hFF;
      8: return m_end_b & 32'hFF;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_start_b = 0; m_end_b = 0; m_snd = 0; m_sft = 0; m_snap_b = 0;
    m_prev_on = 0; m_prev_sf = 0;
  endtask

  // Advance the model by one clock with the inputs currently driven, queue the
  // expected post-edge view, then move to the next falling edge.
  task automatic step();
    bit          reload;
    int unsigned old_snd;
    exp_t        e;
    reload  = (sndon && !m_prev_on) || (sndon && m_prev_sf && !sframe_n);
    old_snd = m_snd;
    if (reload) begin
      m_snd = m_start_b >> 1;
      m_sft = m_end_b >> 1;
    end else if (sndon && sndclk_en) begin
      m_snd = (m_snd + 1) % (1 << 21);
    end
    if (rd_en && rd_sel == 4'd3) m_snap_b = (old_snd << 1) & 32'hFFFF;
    if (wr_en && wr_sel <= 4'd2) m_start_b = set_byte(m_start_b, int'(wr_sel), wr_data);
    if (wr_en && wr_sel >= 4'd6 && wr_sel <= 4'd8)
      m_end_b = set_byte(m_end_b, int'(wr_sel) - 6, wr_data);
    m_prev_on = sndon;
    m_prev_sf = sframe_n;
    e.snd = m_snd;
    e.sft = m_sft;
    e.rd  = model_rd(int'(rd_sel));
    exp_q.push_back(e);
    @(negedge clk32);
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    sndclk_en = 1'b0;
  endtask

  task automatic wr(input logic [3:0] sel, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_data = d;
    rd_sel  = sel;
    step();
  endtask

  task automatic check_reset_view(input string tag);
    check({tag, "_snd"}, 32'(snd), 32'h0);
    check({tag, "_sft"}, 32'(sft), 32'h0);
    for (int s = 0; s < 16; s++) begin
      rd_sel = 4'(s);
      #1;
      check($sformatf("%s_rd_sel%0d", tag, s), 32'(rd_data), 32'h0);
    end
  endtask

  // Monitor: compares the DUT against the queued expectation after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk32);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_snd", 32'(snd), e.snd);
        check("sb_sft", 32'(sft), e.sft);
        check("sb_rd_data", 32'(rd_data), e.rd);
      end
    end
  end

  initial begin
    porb = 1'b0; wr_en = 1'b0; wr_sel = '0; wr_data = '0; rd_en = 1'b0; rd_sel = '0;
    sndon = 1'b0; sndclk_en = 1'b0; sframe_n = 1'b1;
    model_reset();
    #2;
    check_reset_view("por");
    @(negedge clk32);
    porb = 1'b1;
    step();

    // Program start 0x012344 and end 0x012400, then enable.
    wr(4'd0, 8'h01); wr(4'd1, 8'h23); wr(4'd2, 8'h45);
    wr(4'd6, 8'h01); wr(4'd7, 8'h24); wr(4'd8, 8'h00);
    sndon = 1'b1;
    step();
    check("reload_snd", 32'(snd), 32'h091A2);
    check("reload_sft", 32'(sft), 32'h09200);
    repeat (3) begin sndclk_en = 1'b1; step(); end
    check("inc3_snd", 32'(snd), 32'h091A5);
    rd_en = 1'b1; rd_sel = 4'd3; step(); check("cnt_hi", 32'(rd_data), 32'h01);
    rd_sel = 4'd4; step(); check("cnt_mid", 32'(rd_data), 32'h23);
    rd_sel = 4'd5; step(); check("cnt_lo", 32'(rd_data), 32'h4A);

    // Wrap at the top of the address space.
    wr(4'd0, 8'h3F); wr(4'd1, 8'hFF); wr(4'd2, 8'hFE);
    sndon = 1'b0; step();
    sndon = 1'b1; step();
    check("wrap_top", 32'(snd), 32'h1FFFFF);
    sndclk_en = 1'b1; step();
    check("wrap_zero", 32'(snd), 32'h0);

    // Frame restart while running: increment dropped, same-cycle write deferred.
    wr(4'd0, 8'h02); wr(4'd1, 8'h00); wr(4'd2, 8'h00);
    sframe_n = 1'b0; sndclk_en = 1'b1; wr_en = 1'b1; wr_sel = 4'd2; wr_data = 8'h10;
    rd_sel = 4'd2;
    step();
    check("frame_reload", 32'(snd), 32'h10000);
    sframe_n = 1'b1; step();
    sframe_n = 1'b0; step();
    check("frame_reload2", 32'(snd), 32'h10008);
    sframe_n = 1'b1; step();

    // Coherent counter read across increments.
    rd_en = 1'b1; rd_sel = 4'd3; step(); check("snap_hi", 32'(rd_data), 32'h02);
    repeat (5) begin sndclk_en = 1'b1; step(); end
    check("snap_run_snd", 32'(snd), 32'h1000D);
    rd_sel = 4'd4; step(); check("snap_mid", 32'(rd_data), 32'h00);
    rd_sel = 4'd5; step(); check("snap_lo", 32'(rd_data), 32'h10);

    // Asynchronous reset mid-run.
    #2;
    porb = 1'b0;
    #1;
    check_reset_view("midrun");
    model_reset();
    sndon = 1'b0;
    @(negedge clk32);
    porb = 1'b1;
    step();
    sndon = 1'b1; step();
    check("post_reset_snd", 32'(snd), 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        wr_en = 1'b1; wr_sel = 4'($urandom_range(0, 15)); wr_data = 8'($urandom);
      end
      rd_en     = 1'($urandom_range(0, 1));
      rd_sel    = 4'($urandom_range(0, 15));
      sndclk_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) sndon = ~sndon;
      if ($urandom_range(0, 9) == 0) sframe_n = ~sframe_n;
      step();
    end

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
